// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and 16x oversampling constants.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

   localparam int OVERSAMPLE = 16;
   localparam int START_MID  = 7;

   function automatic int cnt_width(input int n, input int min_w);
      return ($clog2(n) < min_w) ? min_w : $clog2(n);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one async bit; 2-clk latency, no backpressure.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled, LSB first, optional even parity; rx_done_tick one clk after the
// s_tick ending the stop interval. No backpressure: a full downstream FIFO drops on its own side.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int SB_TICK   = 16,
   parameter int PARITY_EN = 0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 rx,
   input  logic                 s_tick,
   output logic                 rx_done_tick,
   output logic [DATA_BITS-1:0] dout,
   output logic                 frame_err,
   output logic                 parity_err
);

   localparam int SW = cnt_width(SB_TICK, 4);
   localparam int NW = cnt_width(DATA_BITS, 1);
   localparam logic [SW-1:0] S_MID      = SW'(START_MID);
   localparam logic [SW-1:0] S_BIT_END  = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] S_STOP_END = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST     = NW'(DATA_BITS - 1);

   logic                 w_rx_s;
   rx_state_t            r_state, w_state_nxt;
   logic [SW-1:0]        r_s_cnt, w_s_cnt_nxt;
   logic [NW-1:0]        r_n_cnt, w_n_cnt_nxt;
   logic [DATA_BITS-1:0] r_b, w_b_nxt;
   logic                 r_p_bad, w_p_bad_nxt;
   logic                 r_stop, w_stop_nxt;
   logic                 r_armed, w_armed_nxt;
   logic                 r_done, w_done_nxt;
   logic [DATA_BITS-1:0] r_dout, w_dout_nxt;
   logic                 r_fe, w_fe_nxt;
   logic                 r_pe, w_pe_nxt;
   logic                 w_stop_bit;

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .i_d     (rx),
      .o_q     (w_rx_s)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_s_cnt <= '0;
         r_n_cnt <= '0;
         r_b     <= '0;
         r_p_bad <= 1'b0;
         r_stop  <= 1'b1;
         r_armed <= 1'b1;
         r_done  <= 1'b0;
         r_dout  <= '0;
         r_fe    <= 1'b0;
         r_pe    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_s_cnt <= w_s_cnt_nxt;
         r_n_cnt <= w_n_cnt_nxt;
         r_b     <= w_b_nxt;
         r_p_bad <= w_p_bad_nxt;
         r_stop  <= w_stop_nxt;
         r_armed <= w_armed_nxt;
         r_done  <= w_done_nxt;
         r_dout  <= w_dout_nxt;
         r_fe    <= w_fe_nxt;
         r_pe    <= w_pe_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_s_cnt_nxt = r_s_cnt;
      w_n_cnt_nxt = r_n_cnt;
      w_b_nxt     = r_b;
      w_p_bad_nxt = r_p_bad;
      w_stop_nxt  = r_stop;
      w_armed_nxt = r_armed;
      w_done_nxt  = 1'b0;
      w_dout_nxt  = r_dout;
      w_fe_nxt    = r_fe;
      w_pe_nxt    = r_pe;
      // With a 16-tick stop interval the stop sample and frame end share one tick.
      w_stop_bit  = (r_s_cnt == S_BIT_END) ? w_rx_s : r_stop;
      case (r_state)
         IDLE: begin
            if (r_armed && !w_rx_s) begin
               w_state_nxt = START;
               w_s_cnt_nxt = '0;
            end else if (!r_armed && w_rx_s) begin
               w_armed_nxt = 1'b1;
            end
         end
         START: begin
            if (s_tick) begin
               if (r_s_cnt == S_MID) begin
                  w_state_nxt = w_rx_s ? IDLE : DATA;
                  w_s_cnt_nxt = '0;
                  w_n_cnt_nxt = '0;
               end else begin
                  w_s_cnt_nxt = r_s_cnt + SW'(1);
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (r_s_cnt == S_BIT_END) begin
                  w_s_cnt_nxt = '0;
                  w_b_nxt     = {w_rx_s, r_b[DATA_BITS-1:1]};
                  if (r_n_cnt == N_LAST) begin
                     w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                  end else begin
                     w_n_cnt_nxt = r_n_cnt + NW'(1);
                  end
               end else begin
                  w_s_cnt_nxt = r_s_cnt + SW'(1);
               end
            end
         end
         PARITY: begin
            if (s_tick) begin
               if (r_s_cnt == S_BIT_END) begin
                  w_p_bad_nxt = w_rx_s ^ (^r_b);
                  w_s_cnt_nxt = '0;
                  w_state_nxt = STOP;
               end else begin
                  w_s_cnt_nxt = r_s_cnt + SW'(1);
               end
            end
         end
         STOP: begin
            if (s_tick) begin
               if (r_s_cnt == S_BIT_END) begin
                  w_stop_nxt = w_rx_s;
               end
               if (r_s_cnt == S_STOP_END) begin
                  w_done_nxt  = 1'b1;
                  w_dout_nxt  = r_b;
                  w_fe_nxt    = ~w_stop_bit;
                  w_pe_nxt    = (PARITY_EN != 0) ? r_p_bad : 1'b0;
                  // A low line (break) must go high again before the next start is trusted.
                  w_armed_nxt = w_stop_bit;
                  w_s_cnt_nxt = '0;
                  w_state_nxt = IDLE;
               end else begin
                  w_s_cnt_nxt = r_s_cnt + SW'(1);
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign rx_done_tick = r_done;
   assign dout         = r_dout;
   assign frame_err    = r_fe;
   assign parity_err   = r_pe;

endmodule
